// File: rtl/spmm_pkg.sv
// Shared types and helpers for the sparse-by-dense streaming matrix multiplier.
// Holds the FSM state enum, the accumulator width rule and the output clamp.
package spmm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } spmm_state_t;

    // Full-precision width: one product plus headroom for a full-length dot product.
    function automatic int spmm_acc_width(input int data_w, input int n_cols);
        return 2 * data_w + $clog2(n_cols);
    endfunction

    // Clamp a sign-extended accumulator to the signed range of a data_w-bit result.
    function automatic logic signed [63:0] spmm_saturate(input logic signed [63:0] acc,
                                                         input int data_w);
        logic signed [63:0] v_hi;
        logic signed [63:0] v_lo;
        v_hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        v_lo = -v_hi - 64'sd1;
        if (acc > v_hi) begin
            return v_hi;
        end
        if (acc < v_lo) begin
            return v_lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/spmm_mac_lane.sv
// One result column: signed multiply, full-precision accumulate, clear, output narrowing.
// Output clamps when SPMM_SATURATE_EN is defined, otherwise keeps the low DATA_WIDTH bits.
module spmm_mac_lane
    import spmm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_acc_en,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_w,
    output logic [DATA_WIDTH-1:0] o_res
);

    logic signed [DATA_WIDTH-1:0]   w_x;
    logic signed [DATA_WIDTH-1:0]   w_w;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    assign w_x    = i_x;
    assign w_w    = i_w;
    assign w_prod = w_x * w_w;

    // Clear and accumulate never coincide: beats are refused while a result is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
        end
    end

`ifdef SPMM_SATURATE_EN
    assign o_res = DATA_WIDTH'(spmm_saturate(64'(r_acc), DATA_WIDTH));
`else
    assign o_res = r_acc[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/spmm_stream.sv
// Streams sparse H rows (col,value beats) against a resident dense W, one result row per H row.
// Optional build macro SPMM_SATURATE_EN clamps results instead of truncating them.
module spmm_stream
    import spmm_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int H_NUM_OF_COLS = 16,
    parameter int H_NUM_OF_ROWS = 16,
    parameter int W_NUM_OF_COLS = 8,
    parameter int ACC_WIDTH     = spmm_acc_width(DATA_WIDTH, H_NUM_OF_COLS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  w_wr_en_i,
    input  logic [$clog2(H_NUM_OF_COLS)-1:0]      w_wr_addr_i,
    input  logic [W_NUM_OF_COLS*DATA_WIDTH-1:0]   w_wr_data_i,
    input  logic                                  nz_valid_i,
    output logic                                  nz_ready_o,
    input  logic [$clog2(H_NUM_OF_COLS)-1:0]      nz_col_idx_i,
    input  logic [DATA_WIDTH-1:0]                 nz_value_i,
    input  logic                                  nz_last_i,
    input  logic                                  nz_empty_i,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [W_NUM_OF_COLS*DATA_WIDTH-1:0]   res_data_o,
    output logic [$clog2(H_NUM_OF_ROWS)-1:0]      res_row_idx_o,
    output logic                                  res_last_o,
    output logic                                  busy_o,
    output logic                                  w_err_o
);

    localparam int IDX_W = $clog2(H_NUM_OF_COLS);
    localparam int ROW_W = $clog2(H_NUM_OF_ROWS);
    localparam int RES_W = W_NUM_OF_COLS * DATA_WIDTH;

    spmm_state_t                  r_state;
    logic                         r_nz_ready;
    logic                         r_res_valid;
    logic [RES_W-1:0]             r_res_data;
    logic [ROW_W-1:0]             r_row_idx;
    logic                         r_res_last;
    logic                         r_w_err;
    logic [DATA_WIDTH-1:0]        r_w [H_NUM_OF_COLS][W_NUM_OF_COLS];

    logic                         w_accept;
    logic                         w_acc_en;
    logic                         w_clr;
    logic                         w_col_ok;
    logic                         w_busy;
    logic [RES_W-1:0]             w_lane_res;
    logic [DATA_WIDTH-1:0]        w_lane_wgt [W_NUM_OF_COLS];

    assign w_busy   = (r_state != ST_IDLE);
    assign w_accept = nz_valid_i & r_nz_ready;
    assign w_acc_en = w_accept & ~nz_empty_i;
    assign w_clr    = (r_state == ST_OUTPUT) & r_res_valid & res_ready_i;
    assign w_col_ok = (int'(nz_col_idx_i) < H_NUM_OF_COLS);

    // Weight store: writes land at the clock edge, so a beat in the same cycle reads the old row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < H_NUM_OF_COLS; r++) begin
                for (int j = 0; j < W_NUM_OF_COLS; j++) begin
                    r_w[r][j] <= '0;
                end
            end
            r_w_err <= 1'b0;
        end else if (w_wr_en_i) begin
            if (w_busy) begin
                r_w_err <= 1'b1;
            end else if (int'(w_wr_addr_i) < H_NUM_OF_COLS) begin
                for (int j = 0; j < W_NUM_OF_COLS; j++) begin
                    r_w[w_wr_addr_i][j] <= w_wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < W_NUM_OF_COLS; g++) begin : g_lane
            assign w_lane_wgt[g] = w_col_ok ? r_w[nz_col_idx_i][g] : '0;

            spmm_mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_acc_en (w_acc_en),
                .i_clr    (w_clr),
                .i_x      (nz_value_i),
                .i_w      (w_lane_wgt[g]),
                .o_res    (w_lane_res[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Result is captured one cycle after entering OUTPUT, once the last product is in the lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_nz_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_row_idx   <= '0;
            r_res_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    r_nz_ready <= 1'b1;
                    if (w_accept) begin
                        if (nz_last_i) begin
                            r_state    <= ST_OUTPUT;
                            r_nz_ready <= 1'b0;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_lane_res;
                        r_res_last  <= (r_row_idx == ROW_W'(H_NUM_OF_ROWS - 1));
                    end else if (res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_nz_ready  <= 1'b1;
                        if (r_row_idx == ROW_W'(H_NUM_OF_ROWS - 1)) begin
                            r_row_idx <= '0;
                        end else begin
                            r_row_idx <= r_row_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_nz_ready <= 1'b1;
                end
            endcase
        end
    end

    assign nz_ready_o    = r_nz_ready;
    assign res_valid_o   = r_res_valid;
    assign res_data_o    = r_res_data;
    assign res_row_idx_o = r_row_idx;
    assign res_last_o    = r_res_last;
    assign busy_o        = w_busy;
    assign w_err_o       = r_w_err;

endmodule
